// File: rtl/sap1_sequencer.sv
// sap1_sequencer
// Run-mode controller for the SAP-1 datapath. A six-step T-state sequencer
// decodes the IR opcode nibble into the 12-bit control word that drives the
// shared bus. It also provides run/pause, single-instruction stepping, a halt
// state and a completed-instruction counter for the front panel.
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   clr         synchronous active-high reset
//   run         level: 1 = free-run, 0 = pause at the next instruction boundary
//   step        one-cycle pulse: run exactly one instruction while paused
//   opcode      IR[7:4], only looked at in T4..T6
//   cntrl_bus   {Cp,Ep,nLm,nCe,nLi,nEi,nLa,Ea,Su,Eu,nLb,nLo}
//   t_state     one-hot T1..T6, all zero in IDLE and HALT
//   idle        paused at an instruction boundary
//   halted      an HLT instruction has executed
//   instr_count completed instructions, wraps modulo 2^CNT_W
module sap1_sequencer #(
  parameter logic [3:0] OPC_LDA = 4'h0,
  parameter logic [3:0] OPC_ADD = 4'h1,
  parameter logic [3:0] OPC_SUB = 4'h2,
  parameter logic [3:0] OPC_OUT = 4'hE,
  parameter logic [3:0] OPC_HLT = 4'hF,
  parameter int         CNT_W   = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic             step,
  input  logic [3:0]       opcode,
  output logic [11:0]      cntrl_bus,
  output logic [5:0]       t_state,
  output logic             idle,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  // Control words. NOP leaves every active-low load/enable high.
  localparam logic [11:0] CW_NOP     = 12'h3E3;
  localparam logic [11:0] CW_FETCH1  = 12'h5E3;
  localparam logic [11:0] CW_FETCH2  = 12'hBE3;
  localparam logic [11:0] CW_FETCH3  = 12'h263;
  localparam logic [11:0] CW_IR_MAR  = 12'h1A3;
  localparam logic [11:0] CW_RAM_A   = 12'h2C3;
  localparam logic [11:0] CW_RAM_B   = 12'h2E1;
  localparam logic [11:0] CW_ADD_A   = 12'h3C7;
  localparam logic [11:0] CW_SUB_A   = 12'h3CF;
  localparam logic [11:0] CW_A_OUT   = 12'h3F2;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE, T1, T2, T3, T4, T5, T6, HALT
  } state_t;

  state_t state, state_nxt;
  logic   step_latch, step_latch_nxt;
  logic   count_en;

  // State register, one-instruction latch and instruction counter.
  // clr wins over everything, even in the middle of an instruction.
  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      step_latch  <= 1'b0;
      instr_count <= '0;
    end else begin
      state      <= state_nxt;
      step_latch <= step_latch_nxt;
      if (count_en) begin
        instr_count <= instr_count + CNT_ONE;
      end
    end
  end

  // Next-state logic. Pause is only honoured at T6, so an instruction always
  // runs to completion once T1 has been entered. The step latch remembers
  // that this instruction was started by a step pulse, so T6 returns to IDLE
  // even if run goes high partway through.
  always_comb begin
    state_nxt      = state;
    step_latch_nxt = step_latch;
    count_en       = 1'b0;
    case (state)
      IDLE: begin
        if (run) begin
          state_nxt      = T1;
          step_latch_nxt = 1'b0;
        end else if (step) begin
          state_nxt      = T1;
          step_latch_nxt = 1'b1;
        end
      end
      T1: state_nxt = T2;
      T2: state_nxt = T3;
      T3: state_nxt = T4;
      T4: begin
        // HLT retires at the end of T4 instead of running T5/T6.
        if (opcode == OPC_HLT) begin
          state_nxt      = HALT;
          step_latch_nxt = 1'b0;
          count_en       = 1'b1;
        end else begin
          state_nxt = T5;
        end
      end
      T5: state_nxt = T6;
      T6: begin
        count_en       = 1'b1;
        step_latch_nxt = 1'b0;
        if (run && !step_latch) begin
          state_nxt = T1;
        end else begin
          state_nxt = IDLE;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Control-word decode from the current T-state and opcode. Fetch is the
  // same for every opcode; the opcode is only consulted from T4 on, once the
  // IR has been loaded by the T3 edge.
  always_comb begin
    cntrl_bus = CW_NOP;
    case (state)
      T1: cntrl_bus = CW_FETCH1;
      T2: cntrl_bus = CW_FETCH2;
      T3: cntrl_bus = CW_FETCH3;
      T4: begin
        if (opcode == OPC_LDA || opcode == OPC_ADD || opcode == OPC_SUB) begin
          cntrl_bus = CW_IR_MAR;
        end else if (opcode == OPC_OUT) begin
          cntrl_bus = CW_A_OUT;
        end
      end
      T5: begin
        if (opcode == OPC_LDA) begin
          cntrl_bus = CW_RAM_A;
        end else if (opcode == OPC_ADD || opcode == OPC_SUB) begin
          cntrl_bus = CW_RAM_B;
        end
      end
      T6: begin
        if (opcode == OPC_ADD) begin
          cntrl_bus = CW_ADD_A;
        end else if (opcode == OPC_SUB) begin
          cntrl_bus = CW_SUB_A;
        end
      end
      default: cntrl_bus = CW_NOP;
    endcase
  end

  // Status flags and one-hot T-state indicator for the front panel.
  always_comb begin
    t_state = 6'b000000;
    case (state)
      T1:      t_state = 6'b000001;
      T2:      t_state = 6'b000010;
      T3:      t_state = 6'b000100;
      T4:      t_state = 6'b001000;
      T5:      t_state = 6'b010000;
      T6:      t_state = 6'b100000;
      default: t_state = 6'b000000;
    endcase
    idle   = (state == IDLE);
    halted = (state == HALT);
  end

  // Only one driver may own the shared bus: Ep, !nCe, !nEi, Ea and Eu are
  // mutually exclusive in every state.
  bus_exclusive: assert property (@(posedge clk)
    $countones({cntrl_bus[10], ~cntrl_bus[8], ~cntrl_bus[6],
                cntrl_bus[4], cntrl_bus[2]}) <= 1);

endmodule

// File: tb/tb_sap1_sequencer.sv
// tb_sap1_sequencer
// Self-checking bench for sap1_sequencer. Each scenario task pushes the
// expected per-cycle observation into a scoreboard queue as it drives the
// inputs, then pops and compares it once the clock edge has taken effect.
// A second instance with a 2-bit counter checks counter wrap-around.
module tb_sap1_sequencer;

  logic        clk;
  logic        clr;
  logic        run;
  logic        step;
  logic [3:0]  opcode;
  logic [11:0] cntrl_bus;
  logic [5:0]  t_state;
  logic        idle;
  logic        halted;
  logic [7:0]  instr_count;

  logic [11:0] cntrl_bus2;
  logic [5:0]  t_state2;
  logic        idle2;
  logic        halted2;
  logic [1:0]  instr_count2;

  int compared;
  int mismatched;

  typedef struct packed {
    logic [11:0] bus;
    logic [5:0]  ts;
    logic        idle;
    logic        halted;
    logic [7:0]  cnt;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] wq[$];

  localparam logic [11:0] NOP = 12'h3E3;
  localparam logic [11:0] W_LDA [6] = '{12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2C3, 12'h3E3};
  localparam logic [11:0] W_ADD [6] = '{12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2E1, 12'h3C7};
  localparam logic [11:0] W_SUB [6] = '{12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2E1, 12'h3CF};
  localparam logic [11:0] W_OUT [6] = '{12'h5E3, 12'hBE3, 12'h263, 12'h3F2, 12'h3E3, 12'h3E3};
  localparam logic [11:0] W_UNK [6] = '{12'h5E3, 12'hBE3, 12'h263, 12'h3E3, 12'h3E3, 12'h3E3};
  localparam logic [11:0] W_HLT [4] = '{12'h5E3, 12'hBE3, 12'h263, 12'h3E3};

  sap1_sequencer dut (
    .clk         (clk),
    .clr         (clr),
    .run         (run),
    .step        (step),
    .opcode      (opcode),
    .cntrl_bus   (cntrl_bus),
    .t_state     (t_state),
    .idle        (idle),
    .halted      (halted),
    .instr_count (instr_count)
  );

  sap1_sequencer #(.CNT_W(2)) dut_w2 (
    .clk         (clk),
    .clr         (clr),
    .run         (run),
    .step        (step),
    .opcode      (opcode),
    .cntrl_bus   (cntrl_bus2),
    .t_state     (t_state2),
    .idle        (idle2),
    .halted      (halted2),
    .instr_count (instr_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected observation; t = 1..6 for T1..T6, 0 for IDLE/HALT.
  function automatic exp_t mk(input logic [11:0] b, input int t, input logic i,
                              input logic h, input logic [7:0] c);
    exp_t e;
    e.bus    = b;
    e.ts     = (t == 0) ? 6'b000000 : (6'b000001 << (t - 1));
    e.idle   = i;
    e.halted = h;
    e.cnt    = c;
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t g;
    g.bus    = cntrl_bus;
    g.ts     = t_state;
    g.idle   = idle;
    g.halted = halted;
    g.cnt    = instr_count;
    return g;
  endfunction

  function automatic string fmt(input exp_t e);
    return $sformatf("bus=%h ts=%b idle=%b halt=%b cnt=%0d",
                     e.bus, e.ts, e.idle, e.halted, e.cnt);
  endfunction

  // Reset held two cycles with run low, then the idle state must persist.
  task automatic test_reset();
    exp_t g, e;
    clr = 1'b1; run = 1'b0; step = 1'b0; opcode = 4'h0;
    for (int i = 0; i < 7; i++) begin
      clr = (i < 2);
      sb.push_back(mk(NOP, 0, 1'b1, 1'b0, 8'd0));
      tick();
      g = sample(); e = sb.pop_front(); compared++;
      if (g !== e) begin
        mismatched++;
        $display("[TB] FAIL reset[%0d]: got %s want %s", i, fmt(g), fmt(e));
      end
    end
  endtask

  // Free-running ADD: two instructions back to back, then pause.
  task automatic test_free_run_add();
    exp_t g, e;
    opcode = 4'h1;
    for (int i = 0; i < 13; i++) begin
      run = (i < 12);
      if (i < 12) sb.push_back(mk(W_ADD[i % 6], i % 6 + 1, 1'b0, 1'b0, 8'(i / 6)));
      else        sb.push_back(mk(NOP, 0, 1'b1, 1'b0, 8'd2));
      tick();
      g = sample(); e = sb.pop_front(); compared++;
      if (g !== e) begin
        mismatched++;
        $display("[TB] FAIL add_run[%0d]: got %s want %s", i, fmt(g), fmt(e));
      end
    end
  endtask

  // One stepped SUB from a fresh reset; a step pulse in T3 must be ignored.
  task automatic test_step_sub();
    exp_t g, e;
    run = 1'b0; opcode = 4'h2;
    for (int i = 0; i < 9; i++) begin
      clr  = (i == 0);
      step = (i == 1 || i == 4);
      if (i == 0)      sb.push_back(mk(NOP, 0, 1'b1, 1'b0, 8'd0));
      else if (i < 7)  sb.push_back(mk(W_SUB[i - 1], i, 1'b0, 1'b0, 8'd0));
      else             sb.push_back(mk(NOP, 0, 1'b1, 1'b0, 8'd1));
      tick();
      g = sample(); e = sb.pop_front(); compared++;
      if (g !== e) begin
        mismatched++;
        $display("[TB] FAIL step_sub[%0d]: got %s want %s", i, fmt(g), fmt(e));
      end
    end
    clr = 1'b0; step = 1'b0;
  endtask

  // run dropped during T2 of an LDA: instruction completes, then IDLE;
  // raising run again starts T1 on the next edge.
  task automatic test_pause_mid();
    exp_t g, e;
    opcode = 4'h0;
    for (int i = 0; i < 14; i++) begin
      run = (i < 2) || (i == 7);
      if (i < 6)       sb.push_back(mk(W_LDA[i], i + 1, 1'b0, 1'b0, 8'd1));
      else if (i == 6) sb.push_back(mk(NOP, 0, 1'b1, 1'b0, 8'd2));
      else if (i < 13) sb.push_back(mk(W_LDA[i - 7], i - 6, 1'b0, 1'b0, 8'd2));
      else             sb.push_back(mk(NOP, 0, 1'b1, 1'b0, 8'd3));
      tick();
      g = sample(); e = sb.pop_front(); compared++;
      if (g !== e) begin
        mismatched++;
        $display("[TB] FAIL pause_mid[%0d]: got %s want %s", i, fmt(g), fmt(e));
      end
    end
  endtask

  // OUT, an unused opcode and SUB run back to back without a gap.
  task automatic test_back_to_back();
    exp_t g, e;
    logic [3:0] ops [3];
    ops[0] = 4'hE; ops[1] = 4'h7; ops[2] = 4'h2;
    for (int i = 0; i < 19; i++) begin
      run = (i < 18);
      if (i < 18) begin
        opcode = ops[i / 6];
        case (i / 6)
          0:       sb.push_back(mk(W_OUT[i % 6], i % 6 + 1, 1'b0, 1'b0, 8'(3 + i / 6)));
          1:       sb.push_back(mk(W_UNK[i % 6], i % 6 + 1, 1'b0, 1'b0, 8'(3 + i / 6)));
          default: sb.push_back(mk(W_SUB[i % 6], i % 6 + 1, 1'b0, 1'b0, 8'(3 + i / 6)));
        endcase
      end else begin
        sb.push_back(mk(NOP, 0, 1'b1, 1'b0, 8'd6));
      end
      tick();
      g = sample(); e = sb.pop_front(); compared++;
      if (g !== e) begin
        mismatched++;
        $display("[TB] FAIL b2b[%0d]: got %s want %s", i, fmt(g), fmt(e));
      end
    end
  endtask

  // HLT enters HALT after T4, ignores run/step, and only clr leaves it.
  task automatic test_halt();
    exp_t g, e;
    opcode = 4'hF;
    for (int i = 0; i < 11; i++) begin
      run  = (i < 4) ? 1'b1 : ((i < 9) ? 1'(i % 2) : 1'b0);
      step = (i == 5 || i == 7);
      clr  = (i == 9);
      if (i < 4)      sb.push_back(mk(W_HLT[i], i + 1, 1'b0, 1'b0, 8'd6));
      else if (i < 9) sb.push_back(mk(NOP, 0, 1'b0, 1'b1, 8'd7));
      else            sb.push_back(mk(NOP, 0, 1'b1, 1'b0, 8'd0));
      tick();
      g = sample(); e = sb.pop_front(); compared++;
      if (g !== e) begin
        mismatched++;
        $display("[TB] FAIL halt[%0d]: got %s want %s", i, fmt(g), fmt(e));
      end
    end
    clr = 1'b0; step = 1'b0; run = 1'b0;
  endtask

  // clr during T5 of the second LDA aborts it and zeroes the counter.
  task automatic test_clr_mid();
    exp_t g, e;
    opcode = 4'h0;
    for (int i = 0; i < 13; i++) begin
      run = (i < 11);
      clr = (i == 11);
      if (i < 6)       sb.push_back(mk(W_LDA[i], i + 1, 1'b0, 1'b0, 8'd0));
      else if (i < 11) sb.push_back(mk(W_LDA[i - 6], i - 5, 1'b0, 1'b0, 8'd1));
      else             sb.push_back(mk(NOP, 0, 1'b1, 1'b0, 8'd0));
      tick();
      g = sample(); e = sb.pop_front(); compared++;
      if (g !== e) begin
        mismatched++;
        $display("[TB] FAIL clr_mid[%0d]: got %s want %s", i, fmt(g), fmt(e));
      end
    end
    clr = 1'b0;
  endtask

  // Five ADDs on the 2-bit counter instance: 1,2,3,0,1.
  task automatic test_count_wrap();
    logic [1:0] w;
    clr = 1'b1; run = 1'b0; opcode = 4'h1;
    wq.push_back(2'd0);
    tick();
    clr = 1'b0;
    w = wq.pop_front(); compared++;
    if (instr_count2 !== w) begin
      mismatched++;
      $display("[TB] FAIL wrap_clr: got %0d want %0d", instr_count2, w);
    end
    for (int i = 0; i <= 30; i++) begin
      run = (i < 30);
      if (i > 0 && i % 6 == 0) wq.push_back(2'((i / 6) % 4));
      tick();
      if (i > 0 && i % 6 == 0) begin
        w = wq.pop_front(); compared++;
        if (instr_count2 !== w) begin
          mismatched++;
          $display("[TB] FAIL wrap[%0d]: got %0d want %0d", i / 6, instr_count2, w);
        end
        compared++;
        if (instr_count !== 8'(i / 6)) begin
          mismatched++;
          $display("[TB] FAIL wrap_full[%0d]: got %0d want %0d", i / 6, instr_count, i / 6);
        end
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    clr = 1'b1; run = 1'b0; step = 1'b0; opcode = 4'h0;
    test_reset();
    test_free_run_add();
    test_step_sub();
    test_pause_mid();
    test_back_to_back();
    test_halt();
    test_clr_mid();
    test_count_wrap();
    if (sb.size() != 0 || wq.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d left want 0", sb.size() + wq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/sap1_sequencer.md
Name: sap1_sequencer

Overview:
- Run-mode controller for the SAP-1 datapath: PC, MAR, RAM, IR, accumulator, add/sub unit, B register and output register.
- A 6-state ring counter (T1..T6) decodes the IR opcode nibble into the 12-bit active-low/active-high control word driven onto the shared datapath.
- Adds run/pause, single-instruction stepping, a halt state and an instruction counter, so the front panel can start, step and stop programs.

Parameters:
- OPC_LDA, 4'h0, LDA opcode
- OPC_ADD, 4'h1, ADD opcode
- OPC_SUB, 4'h2, SUB opcode
- OPC_OUT, 4'hE, OUT opcode
- OPC_HLT, 4'hF, HLT opcode
- CNT_W, 8, instruction counter width

Ports:
- clk  input  1  system clock; all state updates on rising edge
- clr  input  1  synchronous active-high reset
- run  input  1  level; 1 = free-run, 0 = pause at next instruction boundary
- step  input  1  one-cycle pulse; executes exactly one instruction while paused
- opcode  input  4  IR[7:4]
- cntrl_bus  output  12  {Cp,Ep,nLm,nCe,nLi,nEi,nLa,Ea,Su,Eu,nLb,nLo}
- t_state  output  6  one-hot T1..T6; 6'b000000 when IDLE or HALT
- idle  output  1  paused at instruction boundary
- halted  output  1  HLT executed
- instr_count  output  CNT_W  completed instructions

Behaviour:
- Interface: one clock (clk); reset clr is synchronous and active-high.
- States: IDLE, T1..T6, HALT.
- Reset (clr=1 at rising edge) overrides everything, including mid-instruction. Next state IDLE, instr_count=0, halted=0, idle=1, t_state=0, cntrl_bus=12'h3E3.
- cntrl_bus is a combinational decode of registered state and opcode. It is valid for the whole T-state; the datapath samples it at the rising edge that ends the T-state.
- NOP word: 12'h3E3 (all loads/enables inactive). Driven in IDLE, HALT and every unused slot.
- IDLE transitions:
  - run=1 -> T1.
  - else step=1 -> T1 with a one-instruction latch set.
  - else stay.
- T1..T5 advance unconditionally to the next T-state; pause is never honoured mid-instruction.
- T6 exit:
  - Increment instr_count (wraps modulo 2^CNT_W).
  - If run=1 and the step latch is clear -> T1; else -> IDLE and clear the step latch.
  - step pulses arriving outside IDLE are ignored.
- Fetch (all opcodes): T1=12'h5E3 (Ep, nLm), T2=12'hBE3 (Cp), T3=12'h263 (nCe, nLi).
- opcode is used only in T4..T6; IR is valid from the T3 edge onward.
- LDA: T4=12'h1A3 (nEi, nLm), T5=12'h2C3 (nCe, nLa), T6=12'h3E3.
- ADD: T4=12'h1A3, T5=12'h2E1 (nCe, nLb), T6=12'h3C7 (Eu, nLa).
- SUB: T4=12'h1A3, T5=12'h2E1, T6=12'h3CF (Su, Eu, nLa).
- OUT: T4=12'h3F2 (Ea, nLo), T5=T6=12'h3E3.
- HLT: T4 drives 12'h3E3. At the end of T4 -> HALT, instr_count increments, halted=1. HALT is left only via clr; run and step are ignored.
- Any other opcode: T4..T6 = 12'h3E3; counts as an instruction.
- Bus exclusivity: at most one of Ep, !nCe, !nEi, Ea, Eu is asserted in any state. Assertions must check this.
- Output flags:
  - idle=1 only in IDLE; halted=1 only in HALT.
  - t_state bit k is set only in state T(k+1).

Test Plan:
- clr=1 for 2 cycles with run=0 -> idle=1, t_state=0, cntrl_bus=12'h3E3, instr_count=0 held indefinitely.
- run=1, opcode=4'h1 constant -> cntrl_bus sequence 5E3, BE3, 263, 1A3, 2E1, 3C7 repeating every 6 cycles. instr_count=1 after the first T6 edge, 2 after the twelfth cycle.
- run=0, single step pulse in IDLE, opcode=4'h2 -> exactly 5E3, BE3, 263, 1A3, 2E1, 3CF, then IDLE with instr_count=1. A step pulse during T3 has no effect.
- run=1, then run dropped during T2 -> instruction completes through T6, then IDLE. Raising run again -> T1 on the next edge.
- opcode=4'hF at T4 -> HALT after the T4 edge, halted=1, cntrl_bus=3E3. Toggling run/step has no effect; clr -> IDLE, halted=0, instr_count=0.
- clr asserted during T5 of LDA -> next cycle IDLE, cntrl_bus=3E3, instr_count=0. CNT_W=2 with 5 instructions -> instr_count wraps to 1.
